iob_axistream_pack: RTL and testbench

//  Downstream consumer of the 8-bit AXI-Stream byte output (tdata/tvalid/tready/tlast).

---
 rtl/iob_axistream_pack_if.sv | 27 ++
 rtl/iob_axistream_pack.sv | 146 ++++++++++++++
 tb/tb_iob_axistream_pack.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_axistream_pack_if.sv
// Byte-in / word-out AXI-Stream bundle for iob_axistream_pack.
// master = byte producer and word consumer; slave = the packer.
interface iob_axistream_pack_if #(
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned NB = DATA_W / 8;

    logic [7:0]        s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic              s_tlast;
    logic [DATA_W-1:0] m_tdata;
    logic [NB-1:0]     m_tkeep;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast
    );
endinterface

// File: rtl/iob_axistream_pack.sv
// Packs an 8-bit AXI-Stream into DATA_W-bit little-endian words with tkeep,
// double-buffered for 1 byte/cycle. Optional idle flush: AXISTREAM_PACK_TIMEOUT_EN.
module iob_axistream_pack #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input logic                 clk,
    input logic                 rst,
    iob_axistream_pack_if.slave bus_io
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(NB + 1);

    if ((DATA_W % 8) != 0 || DATA_W < 16 || TIMEOUT < 1) begin : g_bad_param
        $error("iob_axistream_pack: DATA_W must be a multiple of 8 and >= 16, TIMEOUT >= 1");
    end

    logic [DATA_W-1:0] acc_data_q, acc_data_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic              acc_last_q, acc_last_d;
    logic              acc_full_q, acc_full_d;

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [NB-1:0]     out_keep_q, out_keep_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;

    logic              xfer_c;
    logic              s_tready_c;
    logic              accept_c;
    logic [NB-1:0]     keep_c;

    // Output register takes the accumulator when it is empty or being drained
    assign xfer_c     = acc_full_q & (~out_valid_q | bus_io.m_tready);
    assign s_tready_c = ~rst & (~acc_full_q | xfer_c);
    assign accept_c   = bus_io.s_tvalid & s_tready_c;

    assign bus_io.s_tready = s_tready_c;
    assign bus_io.m_tdata  = out_data_q;
    assign bus_io.m_tkeep  = out_keep_q;
    assign bus_io.m_tlast  = out_last_q;
    assign bus_io.m_tvalid = out_valid_q;

    always_comb begin
        keep_c = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            keep_c[k] = (CNT_W'(k) < acc_cnt_q);
        end
    end

`ifdef AXISTREAM_PACK_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
`endif

    // Accumulator: drained on xfer, then the accepted byte lands in the freed lanes
    always_comb begin
        acc_data_d = acc_data_q;
        acc_cnt_d  = acc_cnt_q;
        acc_last_d = acc_last_q;
        acc_full_d = acc_full_q;
`ifdef AXISTREAM_PACK_TIMEOUT_EN
        idle_d     = idle_q;
`endif
        if (xfer_c) begin
            acc_data_d = '0;
            acc_cnt_d  = '0;
            acc_last_d = 1'b0;
            acc_full_d = 1'b0;
        end
        if (accept_c) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (acc_cnt_d == CNT_W'(k)) begin
                    acc_data_d[8*k +: 8] = bus_io.s_tdata;
                end
            end
            if (acc_cnt_d == CNT_W'(NB - 1) || bus_io.s_tlast) begin
                acc_full_d = 1'b1;
                acc_last_d = bus_io.s_tlast;
            end
            acc_cnt_d = acc_cnt_d + CNT_W'(1);
        end
`ifdef AXISTREAM_PACK_TIMEOUT_EN
        // Idle flush of a partial word; an accepted byte always wins
        if (accept_c) begin
            idle_d = '0;
        end else if (acc_cnt_q != '0 && !acc_full_q) begin
            idle_d = idle_q + IDLE_W'(1);
            if (idle_d == IDLE_W'(TIMEOUT)) begin
                acc_full_d = 1'b1;
                acc_last_d = 1'b0;
                idle_d     = '0;
            end
        end else begin
            idle_d = '0;
        end
`endif
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (xfer_c) begin
            out_data_d  = acc_data_q;
            out_keep_d  = keep_c;
            out_last_d  = acc_last_q;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus_io.m_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_data_q  <= '0;
            acc_cnt_q   <= '0;
            acc_last_q  <= 1'b0;
            acc_full_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_data_q  <= acc_data_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_last_q  <= acc_last_d;
            acc_full_q  <= acc_full_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef AXISTREAM_PACK_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif
endmodule

// File: tb/tb_iob_axistream_pack.sv
// Randomized and directed bench for iob_axistream_pack against a byte-queue model.
module tb_iob_axistream_pack;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NB      = DATA_W / 8;
    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iob_axistream_pack_if #(.DATA_W(DATA_W)) bus ();

    iob_axistream_pack #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: bytes of the word being built, expected words, observed words
    logic [7:0]  part[$];
    logic [36:0] exp_q[$];
    logic [36:0] rx_q[$];
    logic [36:0] got;
    int          stall_cnt = 0;
    int          idle_n = 0;

    function automatic logic [36:0] pack_word(input logic last);
        logic [31:0] d;
        logic [3:0]  k;
        d = '0;
        for (int i = 0; i < part.size(); i++) d = d | (32'(part[i]) << (8 * i));
        k = 4'((1 << part.size()) - 1);
        return {last, k, d};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            part.delete();
            exp_q.delete();
            idle_n = 0;
        end else begin
            if (bus.m_tvalid && bus.m_tready) begin
                got = {bus.m_tlast, bus.m_tkeep, bus.m_tdata};
                rx_q.push_back(got);
                if (exp_q.size() == 0) check("sb_unexpected_word", 64'(exp_q.size()), 64'd1);
                else check("sb_word", 64'(got), 64'(exp_q.pop_front()));
            end
            if (bus.s_tvalid && !bus.s_tready) stall_cnt++;
            if (bus.s_tvalid && bus.s_tready) begin
                part.push_back(bus.s_tdata);
                idle_n = 0;
                if (bus.s_tlast || part.size() == NB) begin
                    exp_q.push_back(pack_word(bus.s_tlast));
                    part.delete();
                end
            end
`ifdef AXISTREAM_PACK_TIMEOUT_EN
            else if (part.size() != 0) begin
                idle_n++;
                if (idle_n == TIMEOUT) begin
                    exp_q.push_back(pack_word(1'b0));
                    part.delete();
                    idle_n = 0;
                end
            end
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one byte from posedge+1; returns whether it was taken within max_wait cycles
    task automatic send(input logic [7:0] b, input logic l, input int max_wait, output bit ok);
        int w;
        w = 0;
        bus.s_tdata  = b;
        bus.s_tlast  = l;
        bus.s_tvalid = 1'b1;
        @(negedge clk);
        while (!bus.s_tready && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        ok = bus.s_tready;
        @(posedge clk);
        #1;
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic send_ok(input logic [7:0] b, input logic l);
        bit ok;
        send(b, l, 200, ok);
        check("send_accept", 64'(ok), 64'd1);
    endtask

    task automatic check_rx(input string tag, input int idx, input logic [36:0] exp);
        if (idx >= rx_q.size()) check(tag, 64'(rx_q.size()), 64'(idx + 1));
        else check(tag, 64'(rx_q[idx]), 64'(exp));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  base;
        int  acc;
        bit  ok;
        bit  b_done;
        bus.s_tdata  = '0;
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        bus.m_tready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", 64'(bus.s_tready), 64'd0);
        check("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
        check("rst_m_tdata", 64'(bus.m_tdata), 64'd0);
        check("rst_m_tkeep", 64'(bus.m_tkeep), 64'd0);
        check("rst_m_tlast", 64'(bus.m_tlast), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(bus.s_tready), 64'd1);
        step(1);

        // Full one-word frame and its latency
        bus.m_tready = 1'b1;
        base = rx_q.size();
        send_ok(8'h11, 1'b0);
        send_ok(8'h22, 1'b0);
        send_ok(8'h33, 1'b0);
        send_ok(8'h44, 1'b1);
        @(negedge clk);
        check("t1_valid_edge_n", 64'(bus.m_tvalid), 64'd0);
        @(negedge clk);
        check("t1_valid_edge_n1", 64'(bus.m_tvalid), 64'd1);
        step(2);
        check_rx("t1_word", base, {1'b1, 4'hF, 32'h44332211});

        // Frame of six bytes: one full word then a partial tail
        base = rx_q.size();
        for (int i = 1; i <= 6; i++) send_ok(8'(i), 1'(i == 6));
        step(4);
        check_rx("t2_word0", base, {1'b0, 4'hF, 32'h04030201});
        check_rx("t2_word1", base + 1, {1'b1, 4'h3, 32'h00000605});

        // Back-pressure: only two words of buffering
        step(2);
        bus.m_tready = 1'b0;
        base = rx_q.size();
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            send(8'(i + 1), 1'(i == 11), 6, ok);
            if (!ok) break;
            acc++;
        end
        check("t3_accepted", 64'(acc), 64'd8);
        @(negedge clk);
        check("t3_ready_low", 64'(bus.s_tready), 64'd0);
        step(1);
        bus.m_tready = 1'b1;
        for (int i = acc; i < 12; i++) send_ok(8'(i + 1), 1'(i == 11));
        step(4);
        check("t3_word_count", 64'(rx_q.size() - base), 64'd3);
        check_rx("t3_word0", base, {1'b0, 4'hF, 32'h04030201});
        check_rx("t3_word1", base + 1, {1'b0, 4'hF, 32'h08070605});
        check_rx("t3_word2", base + 2, {1'b1, 4'hF, 32'h0C0B0A09});

        // 64 bytes back-to-back with the sink always ready
        stall_cnt = 0;
        base = rx_q.size();
        for (int i = 0; i < 64; i++) send_ok(8'($urandom), 1'(i == 63));
        step(4);
        check("t4_no_stall", 64'(stall_cnt), 64'd0);
        check("t4_word_count", 64'(rx_q.size() - base), 64'd16);
        for (int i = 0; i < 16; i++) check_rx("t4_keep", base + i, {rx_q[base + i][36], 4'hF, rx_q[base + i][31:0]});

        // Reset mid-word discards buffered bytes
        send_ok(8'h5A, 1'b0);
        send_ok(8'hA5, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
        check("t5_rst_s_tready", 64'(bus.s_tready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1);
        base = rx_q.size();
        send_ok(8'hAA, 1'b0);
        send_ok(8'hBB, 1'b0);
        send_ok(8'hCC, 1'b0);
        send_ok(8'hDD, 1'b0);
        step(4);
        check("t5_word_count", 64'(rx_q.size() - base), 64'd1);
        check_rx("t5_word", base, {1'b0, 4'hF, 32'hDDCCBBAA});

        // Partial word followed by idle
        base = rx_q.size();
        send_ok(8'h01, 1'b0);
        send_ok(8'h02, 1'b0);
        send_ok(8'h03, 1'b0);
`ifdef AXISTREAM_PACK_TIMEOUT_EN
        acc = -1;
        for (int c = 0; c < int'(TIMEOUT) + 10; c++) begin
            @(negedge clk);
            if (bus.m_tvalid && acc < 0) acc = c;
        end
        check("t6_timeout_window", 64'(acc >= int'(TIMEOUT) && acc <= int'(TIMEOUT) + 2), 64'd1);
        step(2);
        check_rx("t6_flush_word", base, {1'b0, 4'h7, 32'h00030201});
`else
        acc = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.m_tvalid) acc++;
        end
        check("t6_no_flush", 64'(acc), 64'd0);
        step(1);
        send_ok(8'h04, 1'b1);
        step(4);
        check_rx("t6_tlast_word", base, {1'b1, 4'hF, 32'h04030201});
`endif

        // Randomized traffic with random sink back-pressure
        b_done = 1'b0;
        fork
            begin
                while (!b_done) begin
                    @(posedge clk);
                    #1 bus.m_tready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 400; i++) begin
                    step(int'($urandom_range(0, 2)));
                    send_ok(8'($urandom), 1'(($urandom_range(0, 5) == 0) || (i == 399)));
                end
                b_done = 1'b1;
            end
        join
        bus.m_tready = 1'b1;
        step(10);
        check("rand_drain_words", 64'(exp_q.size()), 64'd0);
        check("rand_drain_bytes", 64'(part.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
